// File: rtl/gray_conv_arbiter.sv
// ============================================================================
// gray_conv_arbiter: round-robin shared Gray-to-binary converter. Rev 1.0
// ============================================================================
`default_nettype none

module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_bin,
  output logic [ID_W-1:0]       out_id,
  input  logic                  out_ready
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_gray;
  logic [WIDTH-1:0] sel_bin;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign load = !out_valid || out_ready;

  // Walk the requesters starting at ptr, wrapping, and keep the first valid one.
  always_comb begin : arb_search
    logic [ID_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == LAST_ID) ? '0 : idx + 1'b1;
    end
  end

  assign xfer = found && load && !rst;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready = NREQ'(1) << winner;
    end
  end

  // Only the granted slice reaches the converter; other slices may hold garbage.
  always_comb begin
    sel_gray = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_gray = req_gray[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_bin = gray_to_bin(sel_gray);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_bin   <= sel_bin;
      out_id    <= winner;
      ptr       <= (winner == LAST_ID) ? '0 : winner + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
// ============================================================================
// tb_gray_conv_arbiter: scoreboard bench for gray_conv_arbiter. Rev 1.0
// ============================================================================
`default_nettype none

module tb_gray_conv_arbiter;

  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_gray = '0;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_bin;
  logic [IDW-1:0]    out_id;
  logic              out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Expected results, {id, bin}, oldest first.
  logic [IDW+W-1:0] sb_q[$];

  // Reference state: what the output register and pointer should hold now.
  bit          m_valid = 0;
  int          m_bin   = 0;
  int          m_id    = 0;
  int          m_ptr   = 0;

  gray_conv_arbiter #(.WIDTH(W), .NREQ(NREQ), .ID_W(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_gray  (req_gray),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Binary is the running XOR of the Gray code with all its right shifts.
  function automatic int ref_conv(input int g);
    int b;
    b = 0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b & ((1 << W) - 1);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare the registered state and the grant
  // against the reference, then advance the reference across the next edge.
  task automatic cycle(input logic r, input logic [NREQ-1:0] v,
                       input logic [NREQ*W-1:0] g, input logic ordy);
    int  win;
    int  exp_ready;
    bit  ld;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_gray  = g;
    out_ready = ordy;
    #1;
    check("out_valid", int'(out_valid), int'(m_valid));
    check("out_bin",   int'(out_bin),   m_bin);
    check("out_id",    int'(out_id),    m_id);
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    end
    ld = !m_valid || ordy;
    exp_ready = (!r && ld && win >= 0) ? (1 << win) : 0;
    check("req_ready", int'(req_ready), exp_ready);
    if (r) begin
      m_valid = 0; m_bin = 0; m_id = 0; m_ptr = 0;
      sb_q.delete();
    end else if (ld && win >= 0) begin
      m_valid = 1;
      m_bin   = ref_conv(int'((g >> (win * W)) & ((1 << W) - 1)));
      m_id    = win;
      m_ptr   = (win + 1) % NREQ;
      sb_q.push_back({IDW'(m_id), W'(m_bin)});
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  function automatic logic [NREQ*W-1:0] put(input logic [NREQ*W-1:0] base,
                                            input int i, input logic [W-1:0] val);
    logic [NREQ*W-1:0] r;
    r = base;
    r[i*W +: W] = val;
    return r;
  endfunction

  // Monitor: every completed output handshake consumes one scoreboard entry.
  initial begin : monitor
    logic [IDW+W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: id %0d bin %0d with empty queue", out_id, out_bin);
        end else begin
          e = sb_q.pop_front();
          check("sb_id",  int'(out_id),  int'(e[IDW+W-1:W]));
          check("sb_bin", int'(out_bin), int'(e[W-1:0]));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int sweep_tbl[12];
    logic [NREQ*W-1:0] g;
    sweep_tbl = '{0, 1, 3, 2, 7, 6, 4, 5, 15, 14, 12, 13};

    // Reset and idle
    cycle(1'b1, 4'b0000, '0, 1'b0);
    cycle(1'b1, 4'b0000, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, '0, 1'b1);

    // Single requester sweep with random garbage in the other slices
    for (int k = 0; k < 12; k++) begin
      g = put(NREQ*W'($urandom), 2, W'(k));
      cycle(1'b0, 4'b0100, g, 1'b1);
      @(posedge clk); #1;
      check("sweep_bin", int'(out_bin), sweep_tbl[k]);
      check("sweep_id",  int'(out_id), 2);
    end

    // Fairness from a fresh pointer
    cycle(1'b1, 4'b0000, '0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 4'b1111, 16'h8421 ^ NREQ*W'(k), 1'b1);
      @(posedge clk); #1;
      check("rr_id", int'(out_id), k % NREQ);
    end

    // Backpressure: req 1 loads 0111, then stall with req 3 waiting
    cycle(1'b0, 4'b0010, put('0, 1, 4'b0111), 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'b1000, put('0, 3, 4'b1011), 1'b0);
    cycle(1'b0, 4'b1000, put('0, 3, 4'b1011), 1'b1);
    @(posedge clk); #1;
    check("bp_bin", int'(out_bin), 4'b1101);

    // Wrap and skip: after req 3, 0101 grants req 0, idle gap, then req 2
    cycle(1'b0, 4'b0101, put(put('0, 0, 4'b1000), 2, 4'b0001), 1'b1);
    cycle(1'b0, 4'b0000, '0, 1'b1);
    cycle(1'b0, 4'b0000, '0, 1'b1);
    cycle(1'b0, 4'b0101, put(put('0, 0, 4'b1000), 2, 4'b0001), 1'b1);
    @(posedge clk); #1;
    check("wrap_id", int'(out_id), 2);

    // Reset mid-stall
    cycle(1'b0, 4'b0010, put('0, 1, 4'b0011), 1'b0);
    cycle(1'b0, 4'b0000, '0, 1'b0);
    cycle(1'b1, 4'b1111, 16'hFFFF, 1'b0);
    cycle(1'b0, 4'b1111, 16'h1234, 1'b1);
    @(posedge clk); #1;
    check("rst_stall_id", int'(out_id), 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 63) == 0),
            NREQ'($urandom),
            NREQ*W'($urandom),
            ($urandom_range(0, 9) < 7));
    end

    // Drain and confirm nothing is left outstanding
    for (int n = 0; n < 4; n++) cycle(1'b0, 4'b0000, '0, 1'b1);
    check("sb_leftover", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
